mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Memory stage directly downstream of the execute stage. It consumes the ALU result as the byte address and Val_Rm as the store data, and performs word loads and stores on a local data memory. The memory has a fixed, parameterised access latency, so this stage drives a freeze signal that stalls the pipeline while an access is in progress.

Parameters:
ADDR_BASE, 1024, byte address that maps to memory word 0.
DEPTH, 64, number of 32-bit words in the data memory.
WAIT_CYCLES, 3, number of busy cycles per access; legal range 0..15.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  synchronous, active-low reset.
mem_R_en  input  1  load request from EX/MEM register.
mem_W_en  input  1  store request from EX/MEM register.
alu_result  input  32  byte address from the execute stage.
val_rm  input  32  store data.
mem_result  output  32  load data; valid while ready=1 in DONE.
ready  output  1  combinational; 1 = the current instruction may leave this stage.
freeze  output  1  combinational, equal to ~ready; drives the pipeline-register enables.
addr_err  output  1  1-cycle pulse in DONE when the access address is out of range.

Behaviour:
- req = mem_R_en | mem_W_en. Both asserted at once is treated as a store; mem_result is then 0.
- Word index = (alu_result - ADDR_BASE) >> 2. Address bits [1:0] are ignored.
- Address is in range iff alu_result >= ADDR_BASE and index < DEPTH. An out-of-range store writes nothing; an out-of-range load returns 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, req=0: stay in IDLE; ready=1.
  - IDLE, req=1: latch addr, data and op; cnt <= WAIT_CYCLES-1; go to BUSY, or to DONE if WAIT_CYCLES=0. ready=0 in this cycle.
  - BUSY: ready=0. While cnt!=0, cnt decrements. When cnt=0, go to DONE; on that same edge the store commits to the array, or load data is registered into mem_result.
  - DONE: ready=1, addr_err valid. Always return to IDLE next cycle, even if req is still high. The pipeline advances on this edge, so the request seen in IDLE next cycle belongs to the next instruction.
- Latency: a request first seen at cycle T gives ready=1 at cycle T+WAIT_CYCLES+1. Back-to-back accesses therefore take WAIT_CYCLES+2 cycles each.
- Upstream holds alu_result, val_rm and the enables stable while freeze=1. The stage uses the values latched in IDLE, so input changes after that cycle are ignored.
- mem_result holds its value until the next load completes. It is not cleared on stores or non-memory instructions.
- Reset (rst=0 at an edge): state=IDLE, cnt=0, mem_result=0, addr_err=0. While rst=0, ready=1 and freeze=0. Reset during BUSY aborts the access and no store commits. Reset on the same edge as a commit suppresses the commit. Array contents are not reset.
- cnt is 4 bits; WAIT_CYCLES>15 is illegal and must be caught by an elaboration-time check.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2), ADDR_BASE default, and the word-size shift constant (2).
- One sub-module, data_mem: synchronous single-port DEPTH x 32 array with a write enable, word index, write data and registered read data. mem_stage owns the FSM, counter, address check and handshake.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with mem_W_en=1 -> ready=1, mem_result=0, addr_err=0, and no write occurs.
2. Store, then load, WAIT_CYCLES=3: store 0xDEADBEEF to 1028 -> ready low for exactly 4 cycles. Then load from 1028 -> mem_result=0xDEADBEEF in DONE, 4 freeze cycles.
3. Misaligned and out-of-range: load from 1031 -> returns word 1 (0xDEADBEEF). Store to 1020 and to 1024+256 -> addr_err=1 in DONE and the array is unchanged. Load from 1020 -> 0, addr_err=1.
4. Back-to-back: hold mem_R_en high for two consecutive instructions -> freeze pattern 1,1,1,1,0,1,1,1,1,0. DONE always passes through IDLE.
5. Reset mid-access: store 0x12345678 to 1032, then assert rst=0 in the 2nd BUSY cycle -> state=IDLE, and a later load from 1032 returns the old value.
6. WAIT_CYCLES=0 build: load from 1024 -> one freeze cycle, then ready=1 with data. A simultaneous R+W to 1024 with val_rm=0x5 stores 5 and gives mem_result=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: FSM encoding, default address map
// and word-addressing helpers.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [31:0] ADDR_BASE_DEFAULT = 32'd1024;
   localparam int          WORD_SHIFT        = 2;
   localparam int          CNT_W             = 4;

   // Word offset of a byte address relative to the memory base; bits [1:0] drop out.
   function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
      return (addr - base) >> WORD_SHIFT;
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline-facing bus of the memory stage: request from EX/MEM, load result
// and the ready/freeze handshake back to the pipeline.
interface mem_stage_if;

   logic        mem_R_en;
   logic        mem_W_en;
   logic [31:0] alu_result;
   logic [31:0] val_rm;
   logic [31:0] mem_result;
   logic        ready;
   logic        freeze;
   logic        addr_err;

   modport master (
      output mem_R_en, mem_W_en, alu_result, val_rm,
      input  mem_result, ready, freeze, addr_err
   );

   modport slave (
      input  mem_R_en, mem_W_en, alu_result, val_rm,
      output mem_result, ready, freeze, addr_err
   );

endinterface

// File: rtl/mem_stage_data_mem.sv
// Single-port synchronous word memory with write enable and an enabled,
// registered read port that holds its last value between reads.
module data_mem #(
   parameter int DEPTH = 64,
   parameter int IDX_W = 6
) (
   input  logic             clk,
   input  logic             we,
   input  logic             re,
   input  logic [IDX_W-1:0] idx,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wdata;
      end
      if (re) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: word loads/stores on a local data memory with a fixed access
// latency, stalling the pipeline through freeze while an access is in flight.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
   parameter int          DEPTH       = 64,
   parameter int          WAIT_CYCLES = 3
) (
   input  logic         clk,
   input  logic         rst,
   mem_stage_if.slave   bus
);

   localparam int             IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

   if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("mem_stage: WAIT_CYCLES must lie in 0..15");
   end

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic [IDX_W-1:0]  idx_q;
   logic [31:0]       data_q;
   logic              wr_q;
   logic              rd_q;
   logic              in_range_q;
   logic              zero_q;
   logic              addr_err_q;

   logic              req;
   logic [31:0]       word_off;
   logic              in_range_in;
   logic              cur_wr;
   logic              cur_rd;
   logic              cur_in_range;
   logic [IDX_W-1:0]  cur_idx;
   logic [31:0]       cur_data;
   logic              commit;
   logic              mem_we;
   logic              mem_re;
   logic [31:0]       rdata;

   assign req         = bus.mem_R_en | bus.mem_W_en;
   assign word_off    = word_offset(bus.alu_result, ADDR_BASE);
   assign in_range_in = (bus.alu_result >= ADDR_BASE) && (word_off < 32'(DEPTH));

   // A zero-wait build commits straight from the bus in IDLE; otherwise the latched request is used.
   always_comb begin
      cur_wr       = wr_q;
      cur_rd       = rd_q;
      cur_in_range = in_range_q;
      cur_idx      = idx_q;
      cur_data     = data_q;
      if (state == IDLE) begin
         cur_wr       = bus.mem_W_en;
         cur_rd       = bus.mem_R_en;
         cur_in_range = in_range_in;
         cur_idx      = word_off[IDX_W-1:0];
         cur_data     = bus.val_rm;
      end
   end

   assign commit = rst && (((state == IDLE) && req && (WAIT_CYCLES == 0)) ||
                           ((state == BUSY) && (cnt == '0)));
   assign mem_we = commit && cur_wr && cur_in_range;
   assign mem_re = commit && cur_rd && !cur_wr && cur_in_range;

   data_mem #(
      .DEPTH (DEPTH),
      .IDX_W (IDX_W)
   ) u_data_mem (
      .clk   (clk),
      .we    (mem_we),
      .re    (mem_re),
      .idx   (cur_idx),
      .wdata (cur_data),
      .rdata (rdata)
   );

   // zero_q marks a completed load that must read as 0 (out of range, or R+W treated as a store).
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         cnt        <= '0;
         zero_q     <= 1'b1;
         addr_err_q <= 1'b0;
      end else begin
         addr_err_q <= 1'b0;
         if (commit && cur_rd) begin
            zero_q <= cur_wr || !cur_in_range;
         end
         unique case (state)
            IDLE: begin
               if (req) begin
                  idx_q      <= word_off[IDX_W-1:0];
                  data_q     <= bus.val_rm;
                  wr_q       <= bus.mem_W_en;
                  rd_q       <= bus.mem_R_en;
                  in_range_q <= in_range_in;
                  cnt        <= CNT_INIT;
                  if (WAIT_CYCLES == 0) begin
                     state      <= DONE;
                     addr_err_q <= !in_range_in;
                  end else begin
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  state      <= DONE;
                  addr_err_q <= !in_range_q;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.mem_result = zero_q ? 32'd0 : rdata;
   assign bus.ready      = !rst || ((state == IDLE) && !req) || (state == DONE);
   assign bus.freeze     = ~bus.ready;
   assign bus.addr_err   = addr_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a 3-wait-cycle and a zero-wait instance driven
// from a vector table plus hand-written reset and back-to-back sequences.
module tb_mem_stage;

   logic clk = 1'b0;
   logic rst;
   int   tests    = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mem_stage_if bus3 ();
   mem_stage_if bus0 ();

   mem_stage #(.ADDR_BASE(32'd1024), .DEPTH(64), .WAIT_CYCLES(3)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   mem_stage #(.ADDR_BASE(32'd1024), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0)
   );

   typedef struct {
      bit          sel0;
      bit          rd;
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      int          frz;
      logic [31:0] res;
      bit          err;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs [NV];

   task automatic applyStimulus(input bit sel0, input bit rd, input bit wr,
                                input logic [31:0] addr, input logic [31:0] data);
      bus0.mem_R_en   = sel0 ? rd : 1'b0;
      bus0.mem_W_en   = sel0 ? wr : 1'b0;
      bus0.alu_result = sel0 ? addr : 32'd0;
      bus0.val_rm     = sel0 ? data : 32'd0;
      bus3.mem_R_en   = sel0 ? 1'b0 : rd;
      bus3.mem_W_en   = sel0 ? 1'b0 : wr;
      bus3.alu_result = sel0 ? 32'd0 : addr;
      bus3.val_rm     = sel0 ? 32'd0 : data;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Issues one access, counts freeze cycles until DONE (bounded), checks DONE outputs.
   task automatic doAccess(input string name, input bit sel0, input bit rd, input bit wr,
                           input logic [31:0] addr, input logic [31:0] data,
                           input int exp_frz, input logic [31:0] exp_res, input bit exp_err);
      int          frz;
      logic        rdy;
      logic [31:0] res;
      logic        err;
      frz = 0;
      @(negedge clk);
      applyStimulus(sel0, rd, wr, addr, data);
      #1;
      rdy = sel0 ? bus0.ready : bus3.ready;
      while (!rdy && frz < 40) begin
         frz++;
         @(negedge clk);
         #1;
         rdy = sel0 ? bus0.ready : bus3.ready;
      end
      res = sel0 ? bus0.mem_result : bus3.mem_result;
      err = sel0 ? bus0.addr_err : bus3.addr_err;
      applyStimulus(sel0, 1'b0, 1'b0, 32'd0, 32'd0);
      checkOutput({name, " freeze cycles"}, 32'(frz), 32'(exp_frz));
      checkOutput({name, " mem_result"}, res, exp_res);
      checkOutput({name, " addr_err"}, {31'd0, err}, {31'd0, exp_err});
   endtask

   // Starts a store on the 3-wait instance and pulls reset in the given BUSY cycle (1-based).
   task automatic resetDuringStore(input string name, input logic [31:0] addr,
                                   input logic [31:0] data, input int nbusy);
      @(negedge clk);
      applyStimulus(1'b0, 1'b0, 1'b1, addr, data);
      repeat (nbusy) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      #1;
      checkOutput({name, " ready in reset"}, {31'd0, bus3.ready}, 32'd1);
      checkOutput({name, " mem_result in reset"}, bus3.mem_result, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      #1;
      checkOutput({name, " idle after reset"}, {31'd0, bus3.freeze}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: time limit reached, tests=%0d", tests);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [9:0]  pattern;
      logic [31:0] b2b_res;

      vecs[0]  = '{1'b0, 1'b0, 1'b1, 32'd1024, 32'hAAAA0000, 4, 32'h00000000, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 4, 32'h00000000, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1'b0, 32'd1028, 32'h0,        4, 32'hDEADBEEF, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'd1031, 32'h0,        4, 32'hDEADBEEF, 1'b0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'd1020, 32'h11111111, 4, 32'hDEADBEEF, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'd1280, 32'h22222222, 4, 32'hDEADBEEF, 1'b1};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'd1028, 32'h0,        4, 32'hDEADBEEF, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 32'd1024, 32'h0,        4, 32'hAAAA0000, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'd1020, 32'h0,        4, 32'h00000000, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'd1032, 32'h55555555, 4, 32'h00000000, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b0, 32'd1032, 32'h0,        4, 32'h55555555, 1'b0};
      vecs[11] = '{1'b0, 1'b0, 1'b1, 32'd1276, 32'h600DCAFE, 4, 32'h55555555, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 32'd1276, 32'h0,        4, 32'h600DCAFE, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 32'd1023, 32'h0,        4, 32'h00000000, 1'b1};
      vecs[14] = '{1'b1, 1'b0, 1'b1, 32'd1024, 32'hCAFE0000, 1, 32'h00000000, 1'b0};
      vecs[15] = '{1'b1, 1'b1, 1'b0, 32'd1024, 32'h0,        1, 32'hCAFE0000, 1'b0};
      vecs[16] = '{1'b1, 1'b1, 1'b1, 32'd1024, 32'h00000005, 1, 32'h00000000, 1'b0};
      vecs[17] = '{1'b1, 1'b1, 1'b0, 32'd1024, 32'h0,        1, 32'h00000005, 1'b0};
      vecs[18] = '{1'b1, 1'b1, 1'b0, 32'd1280, 32'h0,        1, 32'h00000000, 1'b1};

      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd1024, 32'hFFFFFFFF);
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset ready", {31'd0, bus3.ready}, 32'd1);
      checkOutput("reset freeze", {31'd0, bus3.freeze}, 32'd0);
      checkOutput("reset mem_result", bus3.mem_result, 32'd0);
      checkOutput("reset addr_err", {31'd0, bus3.addr_err}, 32'd0);
      checkOutput("reset ready zero-wait", {31'd0, bus0.ready}, 32'd1);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("idle ready", {31'd0, bus3.ready}, 32'd1);

      for (int i = 0; i < NV; i++) begin
         doAccess($sformatf("vec%0d", i), vecs[i].sel0, vecs[i].rd, vecs[i].wr,
                  vecs[i].addr, vecs[i].data, vecs[i].frz, vecs[i].res, vecs[i].err);
      end

      // Store held through reset must not reach the array.
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd1024, 32'hFFFFFFFF);
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset2 ready", {31'd0, bus3.ready}, 32'd1);
      checkOutput("reset2 mem_result", bus3.mem_result, 32'd0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      rst = 1'b1;
      doAccess("reset2 readback", 1'b0, 1'b1, 1'b0, 32'd1024, 32'd0, 4, 32'hAAAA0000, 1'b0);

      // Two back-to-back loads with mem_R_en held high.
      @(negedge clk);
      applyStimulus(1'b0, 1'b1, 1'b0, 32'd1028, 32'd0);
      pattern = '0;
      b2b_res = '0;
      for (int i = 0; i < 10; i++) begin
         #1;
         pattern = {pattern[8:0], bus3.freeze};
         if (i == 9) b2b_res = bus3.mem_result;
         if (i < 9) @(negedge clk);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
      checkOutput("b2b freeze pattern", {22'd0, pattern}, {22'd0, 10'b1111011110});
      checkOutput("b2b mem_result", b2b_res, 32'hDEADBEEF);

      resetDuringStore("abort busy2", 32'd1032, 32'h12345678, 2);
      doAccess("abort busy2 readback", 1'b0, 1'b1, 1'b0, 32'd1032, 32'd0, 4, 32'h55555555, 1'b0);
      resetDuringStore("abort commit", 32'd1032, 32'h77777777, 3);
      doAccess("abort commit readback", 1'b0, 1'b1, 1'b0, 32'd1032, 32'd0, 4, 32'h55555555, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
